// File: rtl/ahb_to_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahb_to_apb_bridge
// Description : AHB-Lite slave to APB master bridge with registered outputs.
//               Error responses use two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_to_apb_bridge #(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic                 HREADY,
  input  logic [31:0]          HWDATA,
  output logic                 HREADYOUT,
  output logic [31:0]          HRDATA,
  output logic                 HRESP,
  output logic                 PSEL,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  localparam logic [ADDRWIDTH-1:0] c_align_mask = {{(ADDRWIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_can_accept;

  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept     = w_can_accept && HSEL && HREADY && (HTRANS inside {2'b10, 2'b11});

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_ERR2: w_next = w_accept ? ST_SAMPLE : ST_IDLE;
      ST_SAMPLE:        w_next = ST_SETUP;
      ST_SETUP:         w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          w_next = PSLVERR ? ST_ERR1 : ST_IDLE;
        end
      end
      ST_ERR1:          w_next = ST_ERR2;
      default:          w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are flop outputs that
  // line up with the state they belong to.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'h0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= 32'h0;
    end else begin
      HREADYOUT <= (w_next == ST_IDLE) || (w_next == ST_ERR2);
      HRESP     <= (w_next == ST_ERR1) || (w_next == ST_ERR2);
      PSEL      <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
      PENABLE   <= (w_next == ST_ACCESS);
      if (w_accept) begin
        PADDR  <= HADDR & c_align_mask;
        PWRITE <= HWRITE;
      end
      if ((r_state == ST_SAMPLE) && PWRITE) begin
        PWDATA <= HWDATA;
      end
      // PSLVERR only matters on the cycle the slave completes.
      if ((r_state == ST_ACCESS) && PREADY && !PSLVERR && !PWRITE) begin
        HRDATA <= PRDATA;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_to_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_to_apb_bridge
// Description : Directed self-checking bench for ahb_to_apb_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_to_apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        HSEL = 1'b0;
  logic [15:0] HADDR = 16'h0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = 32'h0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        PSEL;
  logic [15:0] PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_hrdata = 32'h0;

  ahb_to_apb_bridge #(.ADDRWIDTH(16)) u_dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .PSEL      (PSEL),
    .PADDR     (PADDR),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Presents a transfer in the current (idle) cycle and walks it to its
  // completion cycle; returns in that cycle so the caller may chain another.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int waits, input logic err);
    logic [15:0] exp_addr;
    exp_addr = addr & 16'hFFFC;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HREADY = 1'b1;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 16'hFFFF; HWDATA = wdata;
    check("sample_hreadyout", HREADYOUT, 0);
    check("sample_psel", PSEL, 0);
    check("sample_paddr", PADDR, exp_addr);
    check("sample_pwrite", PWRITE, wr);
    tick();
    HWDATA = 32'hFFFF0000;
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    if (wr) check("setup_pwdata", PWDATA, wdata);
    PRDATA = rdata;
    tick();
    for (int i = 0; i <= waits; i++) begin
      check("access_psel", PSEL, 1);
      check("access_penable", PENABLE, 1);
      check("access_hreadyout", HREADYOUT, 0);
      check("access_paddr", PADDR, exp_addr);
      check("access_hrdata_held", HRDATA, exp_hrdata);
      if (wr) check("access_pwdata", PWDATA, wdata);
      PREADY  = (i == waits);
      PSLVERR = (i == waits) ? err : 1'b1;
      tick();
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0BAD0BAD;
    if (err) begin
      check("err1_hreadyout", HREADYOUT, 0);
      check("err1_hresp", HRESP, 1);
      check("err1_psel", PSEL, 0);
      check("err1_hrdata", HRDATA, exp_hrdata);
      tick();
      check("err2_hreadyout", HREADYOUT, 1);
      check("err2_hresp", HRESP, 1);
      check("err2_psel", PSEL, 0);
      tick();
      check("post_err_hresp", HRESP, 0);
      check("post_err_hreadyout", HREADYOUT, 1);
    end else begin
      check("done_hreadyout", HREADYOUT, 1);
      check("done_hresp", HRESP, 0);
      check("done_psel", PSEL, 0);
      check("done_penable", PENABLE, 0);
      if (!wr) exp_hrdata = rdata;
      check("done_hrdata", HRDATA, exp_hrdata);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_psel"}, PSEL, 0);
    check({tag, "_penable"}, PENABLE, 0);
    check({tag, "_hreadyout"}, HREADYOUT, 1);
  endtask

  initial begin
    #2 HRESETn = 1'b0;
    #1;
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_hresp", HRESP, 0);
    check("rst_hrdata", HRDATA, 0);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
    check_idle("post_rst");

    // Zero-wait write.
    xfer(1'b1, 16'h1004, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    tick();

    // Read with three wait states, unaligned address, PSLVERR noise while not ready.
    xfer(1'b0, 16'h2003, 32'h0, 32'h12345678, 3, 1'b0);
    tick();

    // Slave error on a write.
    xfer(1'b1, 16'h3008, 32'hCAFEF00D, 32'h0, 0, 1'b1);
    tick();

    // Back-to-back reads: the second is presented in the first's completion cycle.
    xfer(1'b0, 16'h0010, 32'h0, 32'hAAAA5555, 0, 1'b0);
    xfer(1'b0, 16'h0020, 32'h0, 32'h5555AAAA, 1, 1'b0);
    tick();

    // Transfers that must be ignored.
    HSEL = 1'b1; HTRANS = 2'b01; HREADY = 1'b1; HADDR = 16'h4000;
    tick();
    check_idle("busy_1");
    tick();
    check_idle("busy_2");
    HTRANS = 2'b10; HREADY = 1'b0;
    tick();
    check_idle("nrdy_1");
    tick();
    check_idle("nrdy_2");
    HSEL = 1'b0; HREADY = 1'b1;
    tick();
    check_idle("nsel");
    HTRANS = 2'b00;
    tick();
    check_idle("nsel_2");

    // Reset asserted while ACCESS is stalled.
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 16'h5004;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h01020304;
    tick();
    tick();
    check("mid_penable", PENABLE, 1);
    HRESETn = 1'b0;
    #1;
    check("arst_psel", PSEL, 0);
    check("arst_penable", PENABLE, 0);
    check("arst_hreadyout", HREADYOUT, 1);
    check("arst_hresp", HRESP, 0);
    check("arst_hrdata", HRDATA, 0);
    check("arst_paddr", PADDR, 0);
    check("arst_pwdata", PWDATA, 0);
    check("arst_pwrite", PWRITE, 0);
    exp_hrdata = 32'h0;
    tick();
    HRESETn = 1'b1;
    tick();
    check_idle("after_arst");
    xfer(1'b0, 16'h6008, 32'h0, 32'h89ABCDEF, 0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
